// File: rtl/stepper_chopper_array_pkg.sv
// Shared types, gate-pattern constants and pattern decoder for the coil chopper array.
package stepper_chopper_array_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_BLANK,
        ST_DRIVE,
        ST_DECAY,
        ST_FAULT
    } coil_state_e;

    // Gate vectors are {h1, l1, h2, l2}, active-high.
    localparam logic [3:0] DRIVE_FWD = 4'b1001;
    localparam logic [3:0] DRIVE_REV = 4'b0110;
    localparam logic [3:0] SLOW      = 4'b0101;
    localparam logic [3:0] ALL_OFF   = 4'b0000;

    function automatic logic [3:0] gate_pattern(input coil_state_e st, input logic dir,
                                                input logic fast);
        logic [3:0] g;
        g = ALL_OFF;
        case (st)
            ST_BLANK, ST_DRIVE: g = dir ? DRIVE_FWD : DRIVE_REV;
            ST_DECAY:           g = fast ? (dir ? DRIVE_REV : DRIVE_FWD) : SLOW;
            default:            g = ALL_OFF;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/stepper_chopper_array_if.sv
// Control/config/gate bundle between the microstep datapath and the chopper array.
interface stepper_chopper_array_if #(
    parameter int unsigned NUM_COILS = 2,
    parameter int unsigned OFFTIME_W = 10,
    parameter int unsigned BLANK_W   = 8,
    parameter int unsigned MINON_W   = 8
);
    logic                   enable;
    logic [NUM_COILS-1:0]   coil_dir;
    logic [NUM_COILS-1:0]   coil_cmp;
    logic                   fault_clear;
    logic [OFFTIME_W-1:0]   config_offtime;
    logic [OFFTIME_W-1:0]   config_fastdecay_threshold;
    logic [BLANK_W-1:0]     config_blanktime;
    logic [MINON_W-1:0]     config_minimum_on_time;
    logic                   config_invert_highside;
    logic                   config_invert_lowside;
    logic [2*NUM_COILS-1:0] s_h;
    logic [2*NUM_COILS-1:0] s_l;
    logic [NUM_COILS-1:0]   fault;

    modport master (
        output enable, coil_dir, coil_cmp, fault_clear,
        output config_offtime, config_fastdecay_threshold, config_blanktime,
        output config_minimum_on_time, config_invert_highside, config_invert_lowside,
        input  s_h, s_l, fault
    );

    modport slave (
        input  enable, coil_dir, coil_cmp, fault_clear,
        input  config_offtime, config_fastdecay_threshold, config_blanktime,
        input  config_minimum_on_time, config_invert_highside, config_invert_lowside,
        output s_h, s_l, fault
    );
endinterface

// File: rtl/stepper_chopper_array_coil.sv
// One coil: comparator synchroniser, direction tracker, blank/drive/decay/fault FSM, gate register.
// CHOPPER_FAULT_LATCH_EN: sticky fault cleared by fault_clear; otherwise timed auto-retry.
module chopper_coil
    import stepper_chopper_array_pkg::*;
#(
    parameter int unsigned OFFTIME_W = 10,
    parameter int unsigned BLANK_W   = 8,
    parameter int unsigned MINON_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 dir,
    input  logic                 cmp,
`ifdef CHOPPER_FAULT_LATCH_EN
    input  logic                 fault_clear,
`endif
    input  logic [OFFTIME_W-1:0] cfg_offtime,
    input  logic [OFFTIME_W-1:0] cfg_threshold,
    input  logic [BLANK_W-1:0]   cfg_blanktime,
    input  logic [MINON_W-1:0]   cfg_minon,
    output logic [3:0]           gates,
    output logic                 fault
);
    localparam logic [BLANK_W-1:0]   BLANK_ONE = BLANK_W'(1);
    localparam logic [OFFTIME_W-1:0] OFF_ONE   = OFFTIME_W'(1);
    localparam logic [MINON_W-1:0]   MINON_ONE = MINON_W'(1);

    coil_state_e          state_q, state_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [MINON_W-1:0]   minon_cnt_q, minon_cnt_d;
    logic [OFFTIME_W-1:0] off_cnt_q, off_cnt_d;
    logic                 cmp_meta_q, cmp_meta_d, cmp_s_q, cmp_s_d;
    logic                 dir_q, dir_d, dir_prev_q, dir_prev_d;
    logic [3:0]           gates_q, gates_d;
    logic                 fault_q, fault_d;
    logic                 dir_chg, reload, active;
    logic [BLANK_W-1:0]   blank_load;
    logic [OFFTIME_W-1:0] off_load;

    assign blank_load = (cfg_blanktime == '0) ? BLANK_ONE : cfg_blanktime;
    assign off_load   = (cfg_offtime == '0) ? OFF_ONE : cfg_offtime;
    assign dir_chg    = dir_q ^ dir_prev_q;
    assign active     = (state_q == ST_BLANK) || (state_q == ST_DRIVE) || (state_q == ST_DECAY);

    always_comb begin
        cmp_meta_d  = cmp;
        cmp_s_d     = cmp_meta_q;
        dir_d       = dir;
        dir_prev_d  = dir_q;
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        minon_cnt_d = minon_cnt_q;
        off_cnt_d   = off_cnt_q;
        reload      = 1'b0;

        if (((state_q == ST_BLANK) || (state_q == ST_DRIVE)) && (minon_cnt_q != '0))
            minon_cnt_d = minon_cnt_q - MINON_ONE;

        case (state_q)
            ST_OFF: begin
                if (enable) begin
                    state_d = ST_BLANK;
                    reload  = 1'b1;
                end
            end
            ST_BLANK: begin
                if (blank_cnt_q <= BLANK_ONE) state_d = ST_DRIVE;
                else blank_cnt_d = blank_cnt_q - BLANK_ONE;
            end
            ST_DRIVE: begin
                if (cmp_s_q) begin
                    off_cnt_d = off_load;
                    state_d   = (minon_cnt_q != '0) ? ST_FAULT : ST_DECAY;
                end
            end
            ST_DECAY: begin
                if (off_cnt_q <= OFF_ONE) begin
                    state_d = ST_BLANK;
                    reload  = 1'b1;
                end else begin
                    off_cnt_d = off_cnt_q - OFF_ONE;
                end
            end
            ST_FAULT: begin
`ifdef CHOPPER_FAULT_LATCH_EN
                if (fault_clear) state_d = ST_OFF;
`else
                if (off_cnt_q <= OFF_ONE) state_d = ST_OFF;
                else off_cnt_d = off_cnt_q - OFF_ONE;
`endif
            end
            default: state_d = ST_OFF;
        endcase

        // Disable beats a polarity change, which in turn beats any comparator event this cycle.
        if (active) begin
            if (!enable) begin
                state_d = ST_OFF;
            end else if (dir_chg) begin
                state_d = ST_BLANK;
                reload  = 1'b1;
            end
        end

        if (reload) begin
            blank_cnt_d = blank_load;
            minon_cnt_d = cfg_minon;
        end

        gates_d = gate_pattern(state_d, dir_q, off_cnt_d >= cfg_threshold);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OFF;
            blank_cnt_q <= '0;
            minon_cnt_q <= '0;
            off_cnt_q   <= '0;
            cmp_meta_q  <= 1'b0;
            cmp_s_q     <= 1'b0;
            // Track the pin through reset so release does not look like a polarity change.
            dir_q       <= dir;
            dir_prev_q  <= dir;
            gates_q     <= ALL_OFF;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            blank_cnt_q <= blank_cnt_d;
            minon_cnt_q <= minon_cnt_d;
            off_cnt_q   <= off_cnt_d;
            cmp_meta_q  <= cmp_meta_d;
            cmp_s_q     <= cmp_s_d;
            dir_q       <= dir_d;
            dir_prev_q  <= dir_prev_d;
            gates_q     <= gates_d;
            fault_q     <= fault_d;
        end
    end

    assign gates = gates_q;
    assign fault = fault_q;

endmodule

// File: rtl/stepper_chopper_array.sv
// N-coil current chopper: per-coil FSM instances plus shared enable/config fan-out and pin polarity.
// CHOPPER_FAULT_LATCH_EN selects sticky faults; default build uses timed auto-retry.
module stepper_chopper_array #(
    parameter int unsigned NUM_COILS = 2,
    parameter int unsigned OFFTIME_W = 10,
    parameter int unsigned BLANK_W   = 8,
    parameter int unsigned MINON_W   = 8
) (
    input logic                clk,
    input logic                reset,
    stepper_chopper_array_if.slave bus
);
    for (genvar k = 0; k < NUM_COILS; k++) begin : g_coil
        logic [3:0] gates;

        chopper_coil #(
            .OFFTIME_W (OFFTIME_W),
            .BLANK_W   (BLANK_W),
            .MINON_W   (MINON_W)
        ) u_coil (
            .clk           (clk),
            .reset         (reset),
            .enable        (bus.enable),
            .dir           (bus.coil_dir[k]),
            .cmp           (bus.coil_cmp[k]),
`ifdef CHOPPER_FAULT_LATCH_EN
            .fault_clear   (bus.fault_clear),
`endif
            .cfg_offtime   (bus.config_offtime),
            .cfg_threshold (bus.config_fastdecay_threshold),
            .cfg_blanktime (bus.config_blanktime),
            .cfg_minon     (bus.config_minimum_on_time),
            .gates         (gates),
            .fault         (bus.fault[k])
        );

        assign bus.s_h[2*k]   = gates[3] ^ bus.config_invert_highside;
        assign bus.s_l[2*k]   = gates[2] ^ bus.config_invert_lowside;
        assign bus.s_h[2*k+1] = gates[1] ^ bus.config_invert_highside;
        assign bus.s_l[2*k+1] = gates[0] ^ bus.config_invert_lowside;
    end

endmodule

// File: tb/tb_stepper_chopper_array.sv
// Bench for stepper_chopper_array (NUM_COILS=2): directed vector table, corner sequences, random shoot-through sweep.
module tb_stepper_chopper_array;

    localparam int unsigned NC = 2;

    // Pin patterns {coil1, coil0} with no inversion.
    localparam logic [3:0] FWD_H   = 4'b0101, FWD_L   = 4'b1010;
    localparam logic [3:0] C0REV_H = 4'b0110, C0REV_L = 4'b1001;
    localparam logic [3:0] C0SLW_H = 4'b0100, C0SLW_L = 4'b1011;
    localparam logic [3:0] C0OFF_H = 4'b0100, C0OFF_L = 4'b1000;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stepper_chopper_array_if #(.NUM_COILS(NC), .OFFTIME_W(10), .BLANK_W(8), .MINON_W(8)) bus ();

    stepper_chopper_array #(.NUM_COILS(NC), .OFFTIME_W(10), .BLANK_W(8), .MINON_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        en;
        logic [1:0]  dir;
        logic [1:0]  cmp;
        int unsigned ticks;
        logic [3:0]  sh;
        logic [3:0]  sl;
        logic [1:0]  flt;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] sh;
        logic [3:0] sl;
        logic [1:0] flt;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic vec_t mk(input string n, input logic en, input logic [1:0] d,
                                input logic [1:0] c, input int unsigned t,
                                input logic [3:0] sh, input logic [3:0] sl);
        vec_t v;
        v.name = n; v.en = en; v.dir = d; v.cmp = c; v.ticks = t;
        v.sh = sh; v.sl = sl; v.flt = 2'b00;
        return v;
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic compare_out();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb.pop_front();
        if (bus.s_h !== e.sh || bus.s_l !== e.sl || bus.fault !== e.flt) begin
            errors++;
            $display("FAIL %s: got s_h=%b s_l=%b fault=%b, required s_h=%b s_l=%b fault=%b",
                     e.name, bus.s_h, bus.s_l, bus.fault, e.sh, e.sl, e.flt);
        end
    endtask

    task automatic step(input string n, input int unsigned t, input logic [3:0] sh,
                        input logic [3:0] sl, input logic [1:0] f);
        exp_t e;
        e.name = n; e.sh = sh; e.sl = sl; e.flt = f;
        sb.push_back(e);
        tick(t);
        compare_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] ih, il;

        reset                          = 1'b1;
        bus.enable                     = 1'b0;
        bus.coil_dir                   = 2'b11;
        bus.coil_cmp                   = 2'b00;
        bus.fault_clear                = 1'b0;
        bus.config_offtime             = 10'd20;
        bus.config_fastdecay_threshold = 10'd15;
        bus.config_blanktime           = 8'd5;
        bus.config_minimum_on_time     = 8'd3;
        bus.config_invert_highside     = 1'b0;
        bus.config_invert_lowside      = 1'b0;

        step("reset_state", 3, 4'b0000, 4'b0000, 2'b00);
        reset = 1'b0;
        step("off_after_reset", 2, 4'b0000, 4'b0000, 2'b00);

        vt.push_back(mk("blank_entry",     1'b1, 2'b11, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("blank_hold",      1'b1, 2'b11, 2'b00, 4,  FWD_H,   FWD_L));
        vt.push_back(mk("drive",           1'b1, 2'b11, 2'b00, 2,  FWD_H,   FWD_L));
        vt.push_back(mk("cmp_pulse",       1'b1, 2'b11, 2'b01, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("cmp_sync",        1'b1, 2'b11, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("fast_first",      1'b1, 2'b11, 2'b00, 1,  C0REV_H, C0REV_L));
        vt.push_back(mk("fast_last",       1'b1, 2'b11, 2'b00, 5,  C0REV_H, C0REV_L));
        vt.push_back(mk("slow_first",      1'b1, 2'b11, 2'b00, 1,  C0SLW_H, C0SLW_L));
        vt.push_back(mk("slow_last",       1'b1, 2'b11, 2'b00, 13, C0SLW_H, C0SLW_L));
        vt.push_back(mk("reblank",         1'b1, 2'b11, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("drive2",          1'b1, 2'b11, 2'b00, 5,  FWD_H,   FWD_L));
        vt.push_back(mk("cmp_pulse2",      1'b1, 2'b11, 2'b01, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("dir_flip",        1'b1, 2'b10, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("blank_rev",       1'b1, 2'b10, 2'b00, 1,  C0REV_H, C0REV_L));
        vt.push_back(mk("drive_rev",       1'b1, 2'b10, 2'b00, 6,  C0REV_H, C0REV_L));
        vt.push_back(mk("cmp_pulse3",      1'b1, 2'b10, 2'b01, 1,  C0REV_H, C0REV_L));
        vt.push_back(mk("cmp_sync3",       1'b1, 2'b10, 2'b00, 1,  C0REV_H, C0REV_L));
        vt.push_back(mk("fast_rev",        1'b1, 2'b10, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("fast_rev2",       1'b1, 2'b10, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("dir_in_decay",    1'b1, 2'b11, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("blank_after_dir", 1'b1, 2'b11, 2'b00, 1,  FWD_H,   FWD_L));
        vt.push_back(mk("blank_not_slow",  1'b1, 2'b11, 2'b00, 4,  FWD_H,   FWD_L));
        vt.push_back(mk("enable_off",      1'b0, 2'b11, 2'b00, 1,  4'b0000, 4'b0000));

        foreach (vt[i]) begin
            bus.enable   = vt[i].en;
            bus.coil_dir = vt[i].dir;
            bus.coil_cmp = vt[i].cmp;
            step(vt[i].name, vt[i].ticks, vt[i].sh, vt[i].sl, vt[i].flt);
        end

        // Over-current held from enable with a long minimum on time.
        bus.config_minimum_on_time = 8'd10;
        bus.coil_cmp               = 2'b01;
        bus.enable                 = 1'b1;
        step("fault_pre",   6, FWD_H,   FWD_L,   2'b00);
        step("fault_entry", 1, C0OFF_H, C0OFF_L, 2'b01);
        bus.coil_cmp = 2'b00;
`ifdef CHOPPER_FAULT_LATCH_EN
        step("fault_sticky", 25, C0OFF_H, C0OFF_L, 2'b01);
        bus.fault_clear = 1'b1;
        step("fault_clear", 1, C0OFF_H, C0OFF_L, 2'b00);
        bus.fault_clear = 1'b0;
        step("fault_rearm", 1, FWD_H, FWD_L, 2'b00);
`else
        bus.fault_clear = 1'b1;
        step("clear_ignored", 1, C0OFF_H, C0OFF_L, 2'b01);
        bus.fault_clear = 1'b0;
        step("retry_hold",  18, C0OFF_H, C0OFF_L, 2'b01);
        step("retry_off",   1,  C0OFF_H, C0OFF_L, 2'b00);
        step("retry_blank", 1,  FWD_H,   FWD_L,   2'b00);
`endif

        // Reset while faulted, with inverted pin polarity.
        bus.enable = 1'b0;
        step("off_again", 1, 4'b0000, 4'b0000, 2'b00);
        bus.coil_cmp = 2'b01;
        bus.enable   = 1'b1;
        step("fault_again", 7, C0OFF_H, C0OFF_L, 2'b01);
        reset                      = 1'b1;
        bus.config_invert_highside = 1'b1;
        bus.config_invert_lowside  = 1'b1;
        step("reset_in_fault", 1, 4'b1111, 4'b1111, 2'b00);
        reset        = 1'b0;
        bus.coil_cmp = 2'b00;
        step("inv_blank", 1, ~FWD_H, ~FWD_L, 2'b00);

        for (int unsigned cyc = 0; cyc < 20000; cyc++) begin
            bus.coil_dir    = 2'($urandom);
            bus.coil_cmp    = 2'($urandom);
            bus.enable      = ($urandom_range(0, 15) != 0);
            bus.fault_clear = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 63) == 0) begin
                bus.config_invert_highside = 1'($urandom);
                bus.config_invert_lowside  = 1'($urandom);
            end
            if ($urandom_range(0, 255) == 0) begin
                bus.config_offtime             = 10'($urandom_range(0, 9));
                bus.config_fastdecay_threshold = 10'($urandom_range(0, 9));
                bus.config_blanktime           = 8'($urandom_range(0, 3));
                bus.config_minimum_on_time     = 8'($urandom_range(0, 4));
            end
            tick(1);
            ih = bus.s_h ^ {4{bus.config_invert_highside}};
            il = bus.s_l ^ {4{bus.config_invert_lowside}};
            checks++;
            if ((ih & il) != 4'b0000) begin
                errors++;
                $display("FAIL shoot_through cycle %0d: h=%b l=%b, required h&l=0000", cyc, ih, il);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
